stopwatch_counter: RTL
======================

Name: stopwatch_counter

Overview:
Stopwatch time base and BCD counter that consumes the rst/EN/load control triple produced by the key control block. It counts MM:SS.CC (minutes, seconds, centiseconds) from a divided system clock and presents six BCD digits to the display path. EN and load come from key-driven logic, so both are synchronised to clk; rst is the block's asynchronous reset.

Parameters:
TICK_DIV, 500000, clk cycles per centisecond tick (50 MHz / 100); legal range >= 2
SYNC_STAGES, 2, flip-flop depth of the EN/load synchronisers; legal range >= 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset; clears all state
EN  input  1  count enable level, asynchronous to clk
load  input  1  preset load level, asynchronous to clk
preset_mm  input  8  preset minutes, two BCD digits {tens, units}
preset_ss  input  8  preset seconds, two BCD digits {tens, units}
preset_cc  input  8  preset centiseconds, two BCD digits {tens, units}
cc_lo, cc_hi, ss_lo, ss_hi, mm_lo, mm_hi  output  4 each  BCD display digits
tick  output  1  one-clk pulse on each centisecond advance
wrap  output  1  one-clk pulse when 59:59.99 rolls over to 00:00.00

Behaviour:
- Clock and reset: single clock, clk. Reset rst is asynchronous and active-high.
- Reset value of every output: all digits 0, tick 0, wrap 0. Prescaler 0. Synchroniser flops 0.
- Reset mid-operation: asserting rst at any point clears all state immediately; there is no recovery of the prior count.
- Synchronisation: EN and load each pass through SYNC_STAGES flops, giving en_s and load_s. Input-to-effect latency is SYNC_STAGES clk cycles.
- Priority: rst, then load_s, then en_s.
- Modes (from load_s and en_s):
  - LOAD (load_s=1): each clk, digits <= preset values and prescaler <= 0. tick=0, wrap=0. Holds for as long as load_s stays high.
  - RUN (load_s=0, en_s=1): prescaler counts 0..TICK_DIV-1. On the cycle prescaler==TICK_DIV-1, prescaler <= 0, the time advances by 1 cs, and tick=1 on that cycle.
  - HOLD (load_s=0, en_s=0): prescaler and digits frozen. A partial tick is preserved and resumes when en_s returns.
- Carry chain, all in one cycle:
  - cc_lo 9->0 carries to cc_hi; cc_hi 9->0 carries to ss_lo.
  - ss_lo 9->0 carries to ss_hi; ss_hi 5->0 carries to mm_lo.
  - mm_lo 9->0 carries to mm_hi; mm_hi 5->0 sets wrap=1 on that same tick cycle.
- Preset sanitising (per digit):
  - Any units digit or cc tens digit > 9 loads as 0.
  - ss_hi or mm_hi > 5 loads as 0.
  - Other digits load unchanged.
- Illegal internal digit values cannot arise; no range checks are applied in the count path.
- Outputs are registered: digits change on the tick cycle edge; tick and wrap are registered pulses aligned with the digit update.

Optional Feature:
LAP_HOLD_EN
- Defined:
  - Adds input port lap (1 bit, asynchronous, synchronised like EN) and an internal 24-bit display latch.
  - On a lap_s rising edge, the latch captures the live count and the digit outputs show the latch (frozen) while counting continues internally.
  - The next lap_s rising edge releases the outputs back to the live count.
  - load_s or rst also releases the freeze.
  - tick and wrap always reflect the live count.
- Undefined: no lap port; the digit outputs always show the live count.

Test Plan:
1. TICK_DIV=4: assert rst, release, EN=1 -> first tick 4 cycles after en_s rises; cc_lo steps 0->1->2; tick high 1 cycle per step.
2. TICK_DIV=4: preset 00:00.99, pulse load, then EN=1 -> next tick gives 00:01.00; cc_hi and cc_lo both 0; ss_lo=1.
3. Preset 59:59.99, EN=1 -> next tick gives all digits 0 and wrap=1 for exactly one cycle, on the same cycle as tick.
4. EN=1 then EN=0 mid-prescale (prescaler=2) for 20 cycles, then EN=1 -> tick occurs 2 cycles after en_s returns; digits unchanged during hold.
5. Preset mm=0x7A, ss=0x63, cc=0xA5 -> digits load as mm_hi=0, mm_lo=0, ss_hi=0, ss_lo=3, cc_hi=0, cc_lo=5; load=1 with EN=1 -> digits stay at preset, no tick.
6. Assert rst asynchronously mid-count (no clk edge) -> all digits 0, tick=0, wrap=0 immediately. With LAP_HOLD_EN: lap at 00:00.03 -> outputs hold 00:00.03 while tick continues; second lap -> live value shown.

Source files
------------

// File: rtl/stopwatch_counter.sv
// Stopwatch time base and MM:SS.CC BCD counter with synchronised EN/load controls.
// Optional lap freeze of the digit outputs is enabled by defining LAP_HOLD_EN.
module stopwatch_counter #(
    parameter int TICK_DIV    = 500000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       EN,
    input  logic       load,
`ifdef LAP_HOLD_EN
    input  logic       lap,
`endif
    input  logic [7:0] preset_mm,
    input  logic [7:0] preset_ss,
    input  logic [7:0] preset_cc,
    output logic [3:0] cc_lo,
    output logic [3:0] cc_hi,
    output logic [3:0] ss_lo,
    output logic [3:0] ss_hi,
    output logic [3:0] mm_lo,
    output logic [3:0] mm_hi,
    output logic       tick,
    output logic       wrap
);

    localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);

    // Out-of-range preset digits collapse to zero.
    function automatic logic [3:0] san_digit(input logic [3:0] d, input logic [3:0] max_d);
        if (d > max_d) begin
            return 4'd0;
        end else begin
            return d;
        end
    endfunction

    // One BCD digit step: returns {carry_out, digit}.
    function automatic logic [4:0] bcd_step(input logic [3:0] d, input logic [3:0] max_d,
                                            input logic cin);
        if (!cin) begin
            return {1'b0, d};
        end else if (d == max_d) begin
            return {1'b1, 4'd0};
        end else begin
            return {1'b0, d + 4'd1};
        end
    endfunction

    logic [SYNC_STAGES-1:0] en_sync_r;
    logic [SYNC_STAGES-1:0] load_sync_r;
    logic                   en_s;
    logic                   load_s;
    logic [PW-1:0]          pre_r;
    logic [PW-1:0]          pre_next_s;
    logic [23:0]            count_r;
    logic [23:0]            count_next_s;
    logic [23:0]            count_inc_s;
    logic [23:0]            preset_val_s;
    logic [23:0]            disp_s;
    logic                   wrap_inc_s;
    logic                   tick_r;
    logic                   wrap_r;
    logic                   tick_next_s;
    logic                   wrap_next_s;
    logic [4:0]             st0_s, st1_s, st2_s, st3_s, st4_s, st5_s;

    assign en_s   = en_sync_r[SYNC_STAGES-1];
    assign load_s = load_sync_r[SYNC_STAGES-1];

    assign preset_val_s = {san_digit(preset_mm[7:4], 4'd5), san_digit(preset_mm[3:0], 4'd9),
                           san_digit(preset_ss[7:4], 4'd5), san_digit(preset_ss[3:0], 4'd9),
                           san_digit(preset_cc[7:4], 4'd9), san_digit(preset_cc[3:0], 4'd9)};

    // Full ripple of the +1 cs increment across all six digits.
    always_comb begin
        st0_s       = bcd_step(count_r[3:0],   4'd9, 1'b1);
        st1_s       = bcd_step(count_r[7:4],   4'd9, st0_s[4]);
        st2_s       = bcd_step(count_r[11:8],  4'd9, st1_s[4]);
        st3_s       = bcd_step(count_r[15:12], 4'd5, st2_s[4]);
        st4_s       = bcd_step(count_r[19:16], 4'd9, st3_s[4]);
        st5_s       = bcd_step(count_r[23:20], 4'd5, st4_s[4]);
        count_inc_s = {st5_s[3:0], st4_s[3:0], st3_s[3:0], st2_s[3:0], st1_s[3:0], st0_s[3:0]};
        wrap_inc_s  = st5_s[4];
    end

    // Mode decode: load beats enable; hold freezes prescaler and digits.
    always_comb begin
        count_next_s = count_r;
        pre_next_s   = pre_r;
        tick_next_s  = 1'b0;
        wrap_next_s  = 1'b0;
        if (load_s) begin
            count_next_s = preset_val_s;
            pre_next_s   = '0;
        end else if (en_s) begin
            if (pre_r == PRE_LAST) begin
                pre_next_s   = '0;
                count_next_s = count_inc_s;
                tick_next_s  = 1'b1;
                wrap_next_s  = wrap_inc_s;
            end else begin
                pre_next_s   = pre_r + PW'(1);
            end
        end else begin
            count_next_s = count_r;
            pre_next_s   = pre_r;
        end
    end

    // Synchronisers, prescaler, live count and registered pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_sync_r   <= '0;
            load_sync_r <= '0;
            pre_r       <= '0;
            count_r     <= 24'h000000;
            tick_r      <= 1'b0;
            wrap_r      <= 1'b0;
        end else begin
            en_sync_r   <= {en_sync_r[SYNC_STAGES-2:0], EN};
            load_sync_r <= {load_sync_r[SYNC_STAGES-2:0], load};
            pre_r       <= pre_next_s;
            count_r     <= count_next_s;
            tick_r      <= tick_next_s;
            wrap_r      <= wrap_next_s;
        end
    end

`ifdef LAP_HOLD_EN
    logic [SYNC_STAGES-1:0] lap_sync_r;
    logic                   lap_s;
    logic                   lap_prev_r;
    logic                   lap_rise_s;
    logic                   frozen_r;
    logic [23:0]            latch_r;
    logic [23:0]            disp_r;

    assign lap_s      = lap_sync_r[SYNC_STAGES-1];
    assign lap_rise_s = lap_s & ~lap_prev_r;

    // Lap freeze: first rise captures the live count, next rise or load releases it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_sync_r <= '0;
            lap_prev_r <= 1'b0;
            frozen_r   <= 1'b0;
            latch_r    <= 24'h000000;
            disp_r     <= 24'h000000;
        end else begin
            lap_sync_r <= {lap_sync_r[SYNC_STAGES-2:0], lap};
            lap_prev_r <= lap_s;
            if (load_s) begin
                frozen_r <= 1'b0;
                disp_r   <= count_next_s;
            end else if (lap_rise_s && !frozen_r) begin
                frozen_r <= 1'b1;
                latch_r  <= count_r;
                disp_r   <= count_r;
            end else if (lap_rise_s) begin
                frozen_r <= 1'b0;
                disp_r   <= count_next_s;
            end else if (frozen_r) begin
                disp_r   <= latch_r;
            end else begin
                disp_r   <= count_next_s;
            end
        end
    end

    assign disp_s = disp_r;
`else
    assign disp_s = count_r;
`endif

    assign {mm_hi, mm_lo, ss_hi, ss_lo, cc_hi, cc_lo} = disp_s;
    assign tick = tick_r;
    assign wrap = wrap_r;

endmodule
